// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: write/read handshake and status bundle of the parametrised FIFO
interface param_sync_fifo_if #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 4
);
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    modport master (
        output wr, rd, din,
        input  dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr, rd, din,
        output dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with registered or fall-through read,
// occupancy count, almost thresholds and sticky overflow/underflow flags
module param_sync_fifo #(
    parameter int DATA_W    = 96,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input logic              clk,
    input logic              reset,
    param_sync_fifo_if.slave bus
);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic              r_ovf;
    logic              r_udf;
    logic              w_rd_ok;
    logic              w_wr_ok;

    // a write into a full FIFO is still accepted when a read frees a slot in the same cycle
    always_comb begin
        w_rd_ok     = bus.rd & (r_count != '0);
        w_wr_ok     = bus.wr & ((r_count != LP_DEPTH) | w_rd_ok);
        w_count_nxt = (w_wr_ok & ~w_rd_ok) ? r_count + LP_ONE :
                      (w_rd_ok & ~w_wr_ok) ? r_count - LP_ONE : r_count;
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) r_mem[r_wr_ptr] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= w_count_nxt;
            if (bus.wr && !w_wr_ok) r_ovf <= 1'b1;
            if (bus.rd && !w_rd_ok) r_udf <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [DATA_W-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (reset) r_dout <= '0;
                else if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
            end
            assign bus.dout = r_dout;
        end
    endgenerate

    assign bus.count        = r_count;
    assign bus.empty        = (r_count == '0);
    assign bus.full         = (r_count == LP_DEPTH);
    assign bus.almost_full  = (r_count >= LP_AF);
    assign bus.almost_empty = (r_count <= LP_AE);
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for registered-read and fall-through FIFO instances
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [95:0] m0[$];
    logic [95:0] m1[$];
    logic [95:0] sb0[$];
    logic [95:0] exp_dout0;
    bit          ov0, un0, ov1, un1;

    param_sync_fifo_if #(.DATA_W(96), .ADDR_W(4)) b0();
    param_sync_fifo_if #(.DATA_W(96), .ADDR_W(4)) b1();

    param_sync_fifo #(.FWFT(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    param_sync_fifo #(.FWFT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] st(input int n, input bit ov, input bit un);
        return {5'(n), n == 0, n == 16, n >= 14, n <= 2, ov, un};
    endfunction

    task automatic chk_st0(input string tag);
        check(tag, {b0.count, b0.empty, b0.full, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow},
              st(m0.size(), ov0, un0));
    endtask

    task automatic chk_st1(input string tag);
        check(tag, {b1.count, b1.empty, b1.full, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow},
              st(m1.size(), ov1, un1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b0.wr = 0; b0.rd = 0; b1.wr = 0; b1.rd = 0;
        m0.delete(); m1.delete(); sb0.delete();
        ov0 = 0; un0 = 0; ov1 = 0; un1 = 0;
        exp_dout0 = '0;
        chk_st0("rst_st0");
        chk_st1("rst_st1");
        check("rst_dout0", b0.dout, 96'h0);
    endtask

    task automatic op0(input logic w, input logic r, input logic [95:0] d);
        bit rok, wok;
        b0.wr = w; b0.rd = r; b0.din = d;
        rok = r && m0.size() != 0;
        wok = w && (m0.size() != 16 || rok);
        if (rok) sb0.push_back(m0.pop_front());
        if (wok) m0.push_back(d);
        if (w && !wok) ov0 = 1;
        if (r && !rok) un0 = 1;
        @(posedge clk); #1;
        b0.wr = 0; b0.rd = 0;
        if (rok) exp_dout0 = sb0.pop_front();
        check("dout0", b0.dout, exp_dout0);
        chk_st0("st0");
    endtask

    task automatic op1(input logic w, input logic r, input logic [95:0] d);
        bit rok, wok;
        b1.wr = w; b1.rd = r; b1.din = d;
        rok = r && m1.size() != 0;
        wok = w && (m1.size() != 16 || rok);
        if (rok) void'(m1.pop_front());
        if (wok) m1.push_back(d);
        if (w && !wok) ov1 = 1;
        if (r && !rok) un1 = 1;
        @(posedge clk); #1;
        b1.wr = 0; b1.rd = 0;
        if (m1.size() != 0) check("head1", b1.dout, m1[0]);
        chk_st1("st1");
    endtask

    initial begin
        b0.wr = 0; b0.rd = 0; b0.din = '0;
        b1.wr = 0; b1.rd = 0; b1.din = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // registered read: three writes then three reads
        op0(1, 0, 96'hA1); op0(1, 0, 96'hA2); op0(1, 0, 96'hA3);
        op0(0, 1, 0); check("t1_a1", b0.dout, 96'hA1);
        op0(0, 1, 0); check("t1_a2", b0.dout, 96'hA2);
        op0(0, 1, 0); check("t1_a3", b0.dout, 96'hA3);
        check("t1_empty", b0.empty, 1'b1);
        // fill, then overflow
        for (int i = 0; i < 16; i++) op0(1, 0, 96'h100 + 96'(i));
        check("t2_full", b0.full, 1'b1);
        op0(1, 0, 96'hDEAD);
        check("t2_ovf", b0.overflow, 1'b1);
        check("t2_cnt", b0.count, 5'd16);
        // full with concurrent read and write
        op0(1, 1, 96'hBEEF);
        check("t3_cnt", b0.count, 5'd16);
        for (int i = 0; i < 40; i++)
            op0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom});
        // drain, then underflow
        while (m0.size() != 0) op0(0, 1, 0);
        op0(0, 1, 0);
        check("t4_udf", b0.underflow, 1'b1);
        op0(1, 1, 96'h5);
        check("t4_cnt", b0.count, 5'd1);
        check("t4_udf_sticky", b0.underflow, 1'b1);
        // reset while busy
        while (m0.size() < 9) op0(1, 0, {$urandom, $urandom, $urandom});
        op0(0, 1, 0);
        op0(1, 0, 96'h77);
        check("t6_cnt9", b0.count, 5'd9);
        b0.wr = 1; b0.rd = 1; b0.din = 96'h99;
        do_reset();
        check("t6_flags", {b0.overflow, b0.underflow}, 2'b00);
        // fall-through mode
        op1(1, 0, 96'hAA);
        check("t5_aa", b1.dout, 96'hAA);
        op1(1, 0, 96'hBB);
        check("t5_aa_hold", b1.dout, 96'hAA);
        op1(0, 1, 0);
        check("t5_bb", b1.dout, 96'hBB);
        op1(0, 1, 0);
        op1(1, 1, 96'hCC);
        check("t5_udf", b1.underflow, 1'b1);
        check("t5_cc", b1.dout, 96'hCC);
        for (int i = 0; i < 60; i++)
            op1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom});
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
